// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal TX FIFO and a baud divider.
// Frames are start, data (LSB first), optional parity, then 1 or 2 stop bits.
// Frames run back-to-back while words are queued and tx_en is high.
// The optional line-break feature is enabled by defining UART_TX_BREAK_EN,
// which adds the brk input.
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 2,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef UART_TX_BREAK_EN
  input  logic                          brk,
`endif
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          tx_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [DATA_BITS-1:0]          last_loaded,
  output logic                          overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // BREAK and BRK_REC are only reachable when the break feature is built in.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_BREAK   = 3'd5,
    ST_BRK_REC = 3'd6
  } state_t;

  // Parity bit for a latched word: even (mode 1) or odd (mode 2).
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
    if (PARITY_MODE == 1) begin
      return ^w;
    end else begin
      return ~^w;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        count_r;
  logic [CW-1:0]        count_next_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 overflow_r;
  logic [DATA_BITS-1:0] last_loaded_r;
  logic                 wr_accept_s;
  logic                 pop_s;

  state_t               state_r;
  state_t               state_next_s;
  logic [BW-1:0]        baud_cnt_r;
  logic [BW-1:0]        baud_cnt_next_s;
  logic [IW-1:0]        bit_idx_r;
  logic [IW-1:0]        bit_idx_next_s;
  logic                 stop_cnt_r;
  logic                 stop_cnt_next_s;
  logic [DATA_BITS-1:0] word_r;
  logic                 tx_r;
  logic                 busy_r;
  logic                 tx_next_s;
  logic                 busy_next_s;
  logic                 bit_done_s;
  logic                 frame_ok_s;
  logic                 brk_s;

`ifdef UART_TX_BREAK_EN
  assign brk_s = brk;
`else
  assign brk_s = 1'b0;
`endif

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign full        = full_r;
  assign empty       = empty_r;
  assign fifo_count  = count_r;
  assign last_loaded = last_loaded_r;
  assign overflow    = overflow_r;

  assign wr_accept_s = wr_en && !full_r;
  assign bit_done_s  = (baud_cnt_r == BW'(CLKS_PER_BIT - 1));
  assign frame_ok_s  = !empty_r && tx_en;

  // Next occupancy: a simultaneous write and pop leave the count unchanged.
  always_comb begin
    count_next_s = count_r;
    if (wr_accept_s && !pop_s) begin
      count_next_s = count_r + CW'(1);
    end else if (!wr_accept_s && pop_s) begin
      count_next_s = count_r - CW'(1);
    end else begin
      count_next_s = count_r;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, registered status flags and overflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r      <= {PW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      count_r       <= {CW{1'b0}};
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      overflow_r    <= 1'b0;
      last_loaded_r <= {DATA_BITS{1'b0}};
    end else begin
      if (wr_accept_s) begin
        wr_ptr_r      <= wr_ptr_r + PW'(1);
        last_loaded_r <= wr_data;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r    <= count_next_s;
      full_r     <= (count_next_s == CW'(FIFO_DEPTH));
      empty_r    <= (count_next_s == {CW{1'b0}});
      overflow_r <= wr_en && full_r;
    end
  end

  // Frame sequencer: next state, bit timing counters and FIFO pop request.
  always_comb begin
    state_next_s    = state_r;
    baud_cnt_next_s = baud_cnt_r;
    bit_idx_next_s  = bit_idx_r;
    stop_cnt_next_s = stop_cnt_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        baud_cnt_next_s = {BW{1'b0}};
        if (brk_s) begin
          state_next_s = ST_BREAK;
        end else if (frame_ok_s) begin
          pop_s        = 1'b1;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done_s) begin
          baud_cnt_next_s = {BW{1'b0}};
          bit_idx_next_s  = {IW{1'b0}};
          state_next_s    = ST_DATA;
        end else begin
          baud_cnt_next_s = baud_cnt_r + BW'(1);
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          baud_cnt_next_s = {BW{1'b0}};
          if (bit_idx_r == IW'(DATA_BITS - 1)) begin
            bit_idx_next_s  = {IW{1'b0}};
            stop_cnt_next_s = 1'b0;
            if (PARITY_MODE != 0) begin
              state_next_s = ST_PARITY;
            end else begin
              state_next_s = ST_STOP;
            end
          end else begin
            bit_idx_next_s = bit_idx_r + IW'(1);
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r + BW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_done_s) begin
          baud_cnt_next_s = {BW{1'b0}};
          stop_cnt_next_s = 1'b0;
          state_next_s    = ST_STOP;
        end else begin
          baud_cnt_next_s = baud_cnt_r + BW'(1);
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          baud_cnt_next_s = {BW{1'b0}};
          if (stop_cnt_r == 1'(STOP_BITS - 1)) begin
            stop_cnt_next_s = 1'b0;
            // A break requested during the frame takes priority over the queue.
            if (brk_s) begin
              state_next_s = ST_BREAK;
            end else if (frame_ok_s) begin
              pop_s        = 1'b1;
              state_next_s = ST_START;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            stop_cnt_next_s = 1'b1;
          end
        end else begin
          baud_cnt_next_s = baud_cnt_r + BW'(1);
        end
      end
      ST_BREAK: begin
        baud_cnt_next_s = {BW{1'b0}};
        if (!brk_s) begin
          state_next_s = ST_BRK_REC;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      ST_BRK_REC: begin
        // One full bit time of mark after a break before anything else.
        if (bit_done_s) begin
          baud_cnt_next_s = {BW{1'b0}};
          state_next_s    = ST_IDLE;
        end else begin
          baud_cnt_next_s = baud_cnt_r + BW'(1);
        end
      end
      default: begin
        baud_cnt_next_s = {BW{1'b0}};
        bit_idx_next_s  = {IW{1'b0}};
        stop_cnt_next_s = 1'b0;
        state_next_s    = ST_IDLE;
      end
    endcase
  end

  // Line level and busy for the current state; registered one cycle later.
  always_comb begin
    tx_next_s   = 1'b1;
    busy_next_s = 1'b0;
    case (state_r)
      ST_IDLE:    begin tx_next_s = 1'b1;              busy_next_s = 1'b0; end
      ST_START:   begin tx_next_s = 1'b0;              busy_next_s = 1'b1; end
      ST_DATA:    begin tx_next_s = word_r[bit_idx_r]; busy_next_s = 1'b1; end
      ST_PARITY:  begin tx_next_s = parity_bit(word_r); busy_next_s = 1'b1; end
      ST_STOP:    begin tx_next_s = 1'b1;              busy_next_s = 1'b1; end
      ST_BREAK:   begin tx_next_s = 1'b0;              busy_next_s = 1'b1; end
      ST_BRK_REC: begin tx_next_s = 1'b1;              busy_next_s = 1'b1; end
      default:    begin tx_next_s = 1'b1;              busy_next_s = 1'b0; end
    endcase
  end

  // Sequencer state, latched word and registered line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      baud_cnt_r <= {BW{1'b0}};
      bit_idx_r  <= {IW{1'b0}};
      stop_cnt_r <= 1'b0;
      word_r     <= {DATA_BITS{1'b0}};
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      baud_cnt_r <= baud_cnt_next_s;
      bit_idx_r  <= bit_idx_next_s;
      stop_cnt_r <= stop_cnt_next_s;
      if (pop_s) begin
        word_r <= mem_r[rd_ptr_r];
      end
      tx_r       <= tx_next_s;
      busy_r     <= busy_next_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4. A table of words and
// hand-computed frames (bit 0 = start bit, transmitted first) drives the main
// checks; hand-written sequences cover FIFO full/overflow, back-to-back
// frames, mid-frame reset, tx_en gating, a 7N2 instance and (when built with
// UART_TX_BREAK_EN) the line break.
module tb_uart_tx_fifo;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx_en;
  logic       brk;
  logic       tx;
  logic       busy;
  logic       full;
  logic       empty;
  logic [2:0] fifo_count;
  logic [7:0] last_loaded;
  logic       overflow;

  logic       wr_en7;
  logic [6:0] wr_data7;
  logic       tx_en7;
  logic       brk7;
  logic       tx7;
  logic       busy7;
  logic       full7;
  logic       empty7;
  logic [2:0] count7;
  logic [6:0] last7;
  logic       ovf7;

  logic       sel;
  logic       tx_mon;
  logic       busy_mon;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t tbl [10];

  logic txlog [100];

  uart_tx_fifo #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                 .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef UART_TX_BREAK_EN
    .brk         (brk),
`endif
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .tx_en       (tx_en),
    .tx          (tx),
    .busy        (busy),
    .full        (full),
    .empty       (empty),
    .fifo_count  (fifo_count),
    .last_loaded (last_loaded),
    .overflow    (overflow)
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2),
                 .CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut7 (
    .clk         (clk),
    .rst_n       (rst_n),
`ifdef UART_TX_BREAK_EN
    .brk         (brk7),
`endif
    .wr_en       (wr_en7),
    .wr_data     (wr_data7),
    .tx_en       (tx_en7),
    .tx          (tx7),
    .busy        (busy7),
    .full        (full7),
    .empty       (empty7),
    .fifo_count  (count7),
    .last_loaded (last7),
    .overflow    (ovf7)
  );

  assign tx_mon   = sel ? tx7 : tx;
  assign busy_mon = sel ? busy7 : busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Push one word into the 8-bit instance; returns 1 ns after the accepting edge.
  task automatic push(input logic [7:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    wr_data = 8'hEE;
  endtask

  task automatic push7(input logic [6:0] d);
    @(negedge clk);
    wr_en7   = 1'b1;
    wr_data7 = d;
    @(posedge clk);
    #1;
    wr_en7   = 1'b0;
    wr_data7 = 7'h55;
  endtask

  // Poll for the start bit, bounded; returns 1 ns after the first low edge.
  task automatic wait_start(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (tx_mon === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Entered 1 ns after the edge where the start bit appears; samples each bit
  // mid-period and returns 1 ns after the edge following the last bit.
  task automatic check_frame(input logic [10:0] exp, input int nbits, input string name);
    for (int i = 0; i < nbits; i++) begin
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("%s bit%0d", name, i), 32'(tx_mon), 32'(exp[i]));
      check($sformatf("%s busy%0d", name, i), 32'(busy_mon), 32'd1);
      repeat (2) @(posedge clk);
    end
    #1;
  endtask

  // Single word into an idle, empty FIFO with tx_en high: latency and frame.
  task automatic send_and_check(input int v);
    string nm;
    nm = $sformatf("vec%0d", v);
    push(tbl[v].data);
    check({nm, " count_after_wr"}, 32'(fifo_count), 32'd1);
    @(posedge clk);
    #1;
    check({nm, " tx_high_n1"}, 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    check({nm, " tx_low_n2"}, 32'(tx), 32'd0);
    check_frame(tbl[v].frame, 11, nm);
    check({nm, " tx_idle"}, 32'(tx), 32'd1);
    check({nm, " busy_end"}, 32'(busy), 32'd0);
    check({nm, " empty_end"}, 32'(empty), 32'd1);
    check({nm, " last_loaded"}, 32'(last_loaded), 32'(tbl[v].data));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int lr;
    int hr;
    int s;
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{8'hA5, 11'b1_1_10100101_0};
    tbl[1] = '{8'h00, 11'b1_1_00000000_0};
    tbl[2] = '{8'hFF, 11'b1_1_11111111_0};
    tbl[3] = '{8'h80, 11'b1_0_10000000_0};
    tbl[4] = '{8'h3C, 11'b1_1_00111100_0};
    tbl[5] = '{8'h01, 11'b1_0_00000001_0};
    tbl[6] = '{8'h02, 11'b1_0_00000010_0};
    tbl[7] = '{8'h03, 11'b1_1_00000011_0};
    tbl[8] = '{8'h04, 11'b1_0_00000100_0};
    tbl[9] = '{8'h07, 11'b1_0_00000111_0};

    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; tx_en = 1'b1; brk = 1'b0;
    wr_en7 = 1'b0; wr_data7 = 7'h00; tx_en7 = 1'b0; brk7 = 1'b0; sel = 1'b0;

    // Reset state
    #23;
    check("rst tx", 32'(tx), 32'd1);
    check("rst busy", 32'(busy), 32'd0);
    check("rst full", 32'(full), 32'd0);
    check("rst empty", 32'(empty), 32'd1);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst last_loaded", 32'(last_loaded), 32'd0);
    check("rst overflow", 32'(overflow), 32'd0);
    check("rst tx7", 32'(tx7), 32'd1);
    check("rst empty7", 32'(empty7), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table: single frames (entry 0 is 0xA5 with odd parity)
    for (int v = 0; v < 5; v++) begin
      send_and_check(v);
    end

    // Fill, overflow, then four back-to-back frames in order
    @(negedge clk);
    tx_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push(tbl[5 + k].data);
    end
    check("fill full", 32'(full), 32'd1);
    check("fill count", 32'(fifo_count), 32'd4);
    check("fill empty", 32'(empty), 32'd0);
    push(8'h05);
    check("ovf pulse", 32'(overflow), 32'd1);
    check("ovf count", 32'(fifo_count), 32'd4);
    check("ovf last_loaded", 32'(last_loaded), 32'h04);
    check("ovf full", 32'(full), 32'd1);
    @(posedge clk);
    #1;
    check("ovf pulse end", 32'(overflow), 32'd0);
    @(negedge clk);
    tx_en = 1'b1;
    wait_start("b2b start", 5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("b2b count%0d", k), 32'(fifo_count), 32'(3 - k));
      check_frame(tbl[5 + k].frame, 11, $sformatf("b2b%0d", k));
      if (k < 3) begin
        check($sformatf("b2b no_gap%0d", k), 32'(tx), 32'd0);
      end else begin
        check("b2b idle", 32'(tx), 32'd1);
      end
    end
    check("b2b busy end", 32'(busy), 32'd0);
    check("b2b empty", 32'(empty), 32'd1);

    // Simultaneous write and pop, then reset in the middle of bit 3
    push(tbl[0].data);
    push(tbl[4].data);
    check("wr_pop_same count", 32'(fifo_count), 32'd1);
    wait_start("rst frame start", 5);
    repeat (13) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst tx", 32'(tx), 32'd1);
    check("midrst empty", 32'(empty), 32'd1);
    check("midrst count", 32'(fifo_count), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst last_loaded", 32'(last_loaded), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_and_check(9);

    // 7 data bits, no parity, two stop bits
    sel    = 1'b1;
    tx_en7 = 1'b1;
    push7(7'h7F);
    @(posedge clk);
    #1;
    check("7n2 tx_high_n1", 32'(tx7), 32'd1);
    @(posedge clk);
    #1;
    check("7n2 tx_low_n2", 32'(tx7), 32'd0);
    check_frame(11'b0_1_1_1111111_0, 10, "7n2");
    check("7n2 busy end", 32'(busy7), 32'd0);
    check("7n2 empty", 32'(empty7), 32'd1);
    check("7n2 count", 32'(count7), 32'd0);
    check("7n2 full", 32'(full7), 32'd0);
    check("7n2 overflow", 32'(ovf7), 32'd0);
    check("7n2 last_loaded", 32'(last7), 32'h7F);
    sel = 1'b0;

    // tx_en dropped during the first of two queued frames
    @(negedge clk);
    tx_en = 1'b0;
    push(tbl[4].data);
    push(tbl[2].data);
    @(negedge clk);
    tx_en = 1'b1;
    wait_start("gate start1", 5);
    tx_en = 1'b0;
    check("gate count1", 32'(fifo_count), 32'd1);
    check_frame(tbl[4].frame, 11, "gate1");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("gate hold%0d", i), 32'(tx), 32'd1);
      @(posedge clk);
      #1;
    end
    check("gate busy held", 32'(busy), 32'd0);
    check("gate count held", 32'(fifo_count), 32'd1);
    @(negedge clk);
    tx_en = 1'b1;
    wait_start("gate start2", 5);
    check_frame(tbl[2].frame, 11, "gate2");
    check("gate idle", 32'(tx), 32'd1);
    check("gate empty", 32'(empty), 32'd1);

`ifdef UART_TX_BREAK_EN
    // Break while idle with one word queued
    @(negedge clk);
    tx_en = 1'b0;
    push(tbl[5].data);
    @(negedge clk);
    brk   = 1'b1;
    tx_en = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      txlog[c] = tx;
      if (c == 10) begin
        check("brk busy", 32'(busy), 32'd1);
        check("brk no pop", 32'(fifo_count), 32'd1);
      end
      if (c == 19) begin
        brk = 1'b0;
      end
    end
    f = 100;
    for (int c = 0; c < 100; c++) begin
      if (txlog[c] === 1'b0) begin
        f = c;
        break;
      end
    end
    lr = 0;
    for (int c = f; c < 100; c++) begin
      if (txlog[c] !== 1'b0) break;
      lr++;
    end
    hr = 0;
    for (int c = f + lr; c < 100; c++) begin
      if (txlog[c] !== 1'b1) break;
      hr++;
    end
    s = f + lr + hr;
    check("brk low len", 32'(lr), 32'd20);
    check("brk mark >= 1 bit", 32'(hr >= 4), 32'd1);
    check("brk frame fits", 32'(s + 42 < 100), 32'd1);
    if (s + 42 < 100) begin
      for (int i = 0; i < 11; i++) begin
        check($sformatf("brk frame bit%0d", i), 32'(txlog[s + 4 * i + 2]), 32'(tbl[5].frame[i]));
      end
    end
    check("brk empty", 32'(empty), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
